control_trace_encoder: RTL and testbench
========================================

// Module: control_trace_encoder
// PURPOSE
//  Inverse of the decode-stage control unit. Each valid decode-stage cycle it re-encodes the 20-bit one-hot
//  control vector plus the 4 pipeline flags back into the 5-bit opcode and checks the result for consistency.
//  The result is buffered in a FIFO and drained through a valid/ready debug trace port.
//  Sits beside the decode stage; has no effect on CPU execution.
// PARAMETERS
//  PC_W   8  width of captured program counter
//  DEPTH  8  FIFO entries (power of 2, >=2)
//  CNT_W  16 width of saturating statistics counters
// PORTS
//  clk          in  1        system clock, all logic on rising edge
//  rst_n        in  1        asynchronous active-low reset
//  in_valid     in  1        decode-stage sample is valid this cycle
//  in_ctrl      in  20       one-hot control vector, bit19..bit0
//  in_flags     in  4        {BranchD,regwriteD,memtoregD,memwriteD}
//  in_pc        in  PC_W     PC of the decoded instruction
//  out_valid    out 1        trace record available
//  out_ready    in  1        sink accepts record
//  out_data     out PC_W+11  {pc,opcode[4:0],flags[3:0],onehot_err,flag_err}
//  drop_cnt     out CNT_W    records lost because FIFO full (saturating)
//  err_cnt      out CNT_W    records with onehot_err|flag_err (saturating)
//  overflow     out 1        sticky: any drop since reset/clear
//  cnt_clr      in  1        synchronous clear of drop_cnt, err_cnt, overflow
// BEHAVIOUR
//  Reset: FIFO empty, out_valid=0, out_data=0, drop_cnt=0, err_cnt=0, overflow=0.
//  Encode map, bit->opcode: bit19..bit4 -> 5'b00000..5'b01111 (bit k -> 19-k);
//   bit3 -> 10000, bit2 -> 11101, bit1 -> 11110, bit0 -> 11111.
//  onehot_err=1 when zero or >1 bits set. Opcode is then that of the highest set bit, or 00000 if none.
//  Expected flags: opcodes 00000-01001, 11101-11111 -> 0100; 01010-01110 -> 1000;
//   01111 -> 0110; 10000 -> 0101.
//  flag_err=1 when in_flags != expected. Forced 0 when onehot_err=1 and in_ctrl==0.
//  Push: in_valid sampled each clk. Record is written on that edge if FIFO not full,
//   or if full AND a pop occurs the same edge (simultaneous push+pop when full is accepted).
//  Otherwise the record is dropped: drop_cnt+1 (saturate at all-ones), overflow<=1.
//  Pop: out_valid & out_ready on a clk edge. out_data must hold stable while out_valid & !out_ready.
//  Latency: record pushed at edge N is visible on out_data/out_valid after edge N (earliest) if FIFO empty.
//   No combinational bypass from in_* to out_*.
//  Ordering strictly FIFO; read/write pointers wrap modulo DEPTH; full/empty from an extra pointer bit.
//  err_cnt increments (saturating) per accepted record with either error bit; dropped records not counted.
//  cnt_clr: clears counters/overflow at the edge. If a drop/err coincides with it, clear wins (result 0).
//   FIFO contents are unaffected.
//  Reset asserted mid-operation: FIFO contents discarded immediately; outputs return to reset values.
// TESTING
//  in_ctrl=20'h80000, flags=0100, pc=8'h10 -> next cycle out_data={10,00000,0100,0,0}, out_valid=1.
//  Sweep all 20 one-hot vectors with correct flags -> opcodes 00..0F,10,1D,1E,1F in order, err_cnt=0.
//  in_ctrl=20'h00018 (LD|ST), flags 0110 -> opcode 01111, onehot_err=1, err_cnt=1.
//   in_ctrl=0 -> opcode 00000, onehot_err=1, flag_err=0.
//  BEQ vector 20'h00100 with flags 0100 -> opcode 01011, flag_err=1.
//  out_ready=0, push DEPTH+3 records -> DEPTH held, drop_cnt=3, overflow=1.
//   Then push+pop on same edge while full -> accepted, drop_cnt stays 3.
//  Fill 5 entries, pulse rst_n low mid-burst -> out_valid=0 and counters 0 asynchronously.
//   cnt_clr with a simultaneous drop -> drop_cnt=0.

Source files
------------

// File: rtl/control_trace_encoder.sv
// Re-encodes the decode-stage one-hot control vector and flags into an opcode trace record,
// flags consistency errors, and queues records in a FIFO drained over a valid/ready port.
module control_trace_encoder #(
    parameter int PC_W  = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [19:0]      in_ctrl,
    input  logic [3:0]       in_flags,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W+10:0] out_data,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             overflow,
    input  logic             cnt_clr
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PTR_W = AW + 1;
    localparam int REC_W = PC_W + 11;

    logic [4:0]       w_op_tbl [20];
    logic [4:0]       w_opcode;
    logic [4:0]       w_ones;
    logic [3:0]       w_exp_flags;
    logic             w_onehot_err;
    logic             w_flag_err;
    logic [REC_W-1:0] w_rec;

    logic [REC_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_drop_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic             r_overflow;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_rec_err;

    // Opcode assigned to each control bit; the upper 16 bits count up from 0 as the bit index falls.
    generate
        for (genvar gi = 0; gi < 20; gi++) begin : g_op_tbl
            if (gi >= 4) begin : g_linear
                assign w_op_tbl[gi] = 5'(19 - gi);
            end else if (gi == 3) begin : g_b3
                assign w_op_tbl[gi] = 5'b10000;
            end else if (gi == 2) begin : g_b2
                assign w_op_tbl[gi] = 5'b11101;
            end else if (gi == 1) begin : g_b1
                assign w_op_tbl[gi] = 5'b11110;
            end else begin : g_b0
                assign w_op_tbl[gi] = 5'b11111;
            end
        end
    endgenerate

    // Ascending scan so the highest set bit wins when several are set.
    always_comb begin
        w_opcode = 5'd0;
        w_ones   = 5'd0;
        for (int k = 0; k < 20; k++) begin
            if (in_ctrl[k]) begin
                w_opcode = w_op_tbl[k];
                w_ones   = w_ones + 5'd1;
            end
        end
    end

    always_comb begin
        if (w_opcode >= 5'd10 && w_opcode <= 5'd14) begin
            w_exp_flags = 4'b1000;
        end else if (w_opcode == 5'd15) begin
            w_exp_flags = 4'b0110;
        end else if (w_opcode == 5'd16) begin
            w_exp_flags = 4'b0101;
        end else begin
            w_exp_flags = 4'b0100;
        end
    end

    // An all-zero vector has no instruction to compare flags against.
    assign w_onehot_err = (w_ones != 5'd1);
    assign w_flag_err   = (in_ctrl != 20'd0) && (in_flags != w_exp_flags);
    assign w_rec        = {in_pc, w_opcode, in_flags, w_onehot_err, w_flag_err};
    assign w_rec_err    = w_onehot_err | w_flag_err;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    assign w_push  = in_valid && (!w_full || w_pop);
    assign w_drop  = in_valid && !w_push;

    assign out_valid = !w_empty;
    assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
    assign drop_cnt  = r_drop_cnt;
    assign err_cnt   = r_err_cnt;
    assign overflow  = r_overflow;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (cnt_clr) begin
                r_drop_cnt <= '0;
                r_err_cnt  <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (w_drop) begin
                    r_overflow <= 1'b1;
                    if (r_drop_cnt != '1) begin
                        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end
                end
                if (w_push && w_rec_err && (r_err_cnt != '1)) begin
                    r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_control_trace_encoder.sv
// Directed bench for control_trace_encoder: a queue-based reference model checked every cycle,
// plus literal expectations for the documented examples.
module tb_control_trace_encoder;
    localparam int PC_W  = 8;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [19:0]       in_ctrl;
    logic [3:0]        in_flags;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W+10:0]  out_data;
    logic [CNT_W-1:0]  drop_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              overflow;
    logic              cnt_clr;

    int errors = 0;
    int checks = 0;

    control_trace_encoder #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ctrl(in_ctrl),
        .in_flags(in_flags), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .drop_cnt(drop_cnt), .err_cnt(err_cnt), .overflow(overflow),
        .cnt_clr(cnt_clr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: derive the record straight from the encode rules.
    function automatic logic [PC_W+10:0] model_rec(input logic [19:0] c, input logic [3:0] f,
                                                   input logic [PC_W-1:0] p);
        int hi;
        int n;
        logic [4:0] op;
        logic [3:0] ef;
        hi = -1;
        n  = 0;
        for (int k = 0; k < 20; k++) begin
            if (c[k]) begin
                n++;
                hi = k;
            end
        end
        if (hi < 0)       op = 5'd0;
        else if (hi >= 4) op = 5'(19 - hi);
        else if (hi == 3) op = 5'd16;
        else if (hi == 2) op = 5'd29;
        else if (hi == 1) op = 5'd30;
        else              op = 5'd31;
        if (op >= 10 && op <= 14) ef = 4'b1000;
        else if (op == 15)        ef = 4'b0110;
        else if (op == 16)        ef = 4'b0101;
        else                      ef = 4'b0100;
        return {p, op, f, (n != 1), (c != 20'd0) && (f != ef)};
    endfunction

    logic [PC_W+10:0] mq[$];
    int               m_drop;
    int               m_err;
    bit               m_ovf;
    bit               m_pop;
    bit               m_drop_now;
    logic [PC_W+10:0] m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_drop = 0;
            m_err  = 0;
            m_ovf  = 0;
        end else begin
            m_pop      = (mq.size() > 0) && out_ready;
            m_drop_now = in_valid && (mq.size() == DEPTH) && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (in_valid && !m_drop_now) begin
                m_r = model_rec(in_ctrl, in_flags, in_pc);
                mq.push_back(m_r);
                if ((m_r[1] || m_r[0]) && m_err < 65535) m_err++;
            end
            if (m_drop_now) begin
                if (m_drop < 65535) m_drop++;
                m_ovf = 1;
            end
            if (cnt_clr) begin
                m_drop = 0;
                m_err  = 0;
                m_ovf  = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) chk("m_data", 32'(out_data), 32'(mq[0]));
            chk("m_drop", 32'(drop_cnt), 32'(m_drop));
            chk("m_err", 32'(err_cnt), 32'(m_err));
            chk("m_ovf", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic step(input bit v, input logic [19:0] c, input logic [3:0] f,
                        input logic [7:0] p, input bit rdy, input bit clr);
        in_valid  = v;
        in_ctrl   = c;
        in_flags  = f;
        in_pc     = p;
        out_ready = rdy;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
        $display("step v=%0d ctrl=%05h flags=%04b pc=%02h rdy=%0d clr=%0d -> ov=%0d data=%05h drop=%0d err=%0d",
                 v, c, f, p, rdy, clr, out_valid, out_data, drop_cnt, err_cnt);
    endtask

    logic [4:0]       exp_op [20];
    logic [3:0]       exp_fl [20];
    logic [PC_W+10:0] lit;

    initial begin
        for (int i = 0; i < 16; i++) exp_op[i] = 5'(i);
        exp_op[16] = 5'h10; exp_op[17] = 5'h1D; exp_op[18] = 5'h1E; exp_op[19] = 5'h1F;
        for (int i = 0; i < 20; i++) exp_fl[i] = 4'b0100;
        for (int i = 10; i < 15; i++) exp_fl[i] = 4'b1000;
        exp_fl[15] = 4'b0110;
        exp_fl[16] = 4'b0101;

        rst_n = 1'b1; in_valid = 0; in_ctrl = 0; in_flags = 0; in_pc = 0;
        out_ready = 0; cnt_clr = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        chk("rst_err", 32'(err_cnt), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // First record visible right after its push edge.
        step(1, 20'h80000, 4'b0100, 8'h10, 0, 0);
        lit = {8'h10, 5'b00000, 4'b0100, 1'b0, 1'b0};
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", 32'(out_data), 32'(lit));
        step(0, 0, 0, 0, 1, 0);

        // Sweep bit19..bit0 with correct flags.
        for (int i = 0; i < 20; i++) begin
            step(1, 20'(1) << (19 - i), exp_fl[i], 8'(i), 1, 0);
            chk("sweep_op", 32'(out_data[10:6]), 32'(exp_op[i]));
            chk("sweep_err", 32'(out_data[1:0]), 32'd0);
        end
        step(0, 0, 0, 0, 1, 0);
        chk("sweep_errcnt", 32'(err_cnt), 32'd0);

        step(1, 20'h00018, 4'b0110, 8'h21, 1, 0);
        chk("multi_op", 32'(out_data[10:6]), 32'h0F);
        chk("multi_oh", 32'(out_data[1]), 32'd1);
        chk("multi_fe", 32'(out_data[0]), 32'd0);
        chk("multi_errcnt", 32'(err_cnt), 32'd1);

        step(1, 20'h00000, 4'b0000, 8'h22, 1, 0);
        chk("zero_op", 32'(out_data[10:6]), 32'd0);
        chk("zero_oh", 32'(out_data[1]), 32'd1);
        chk("zero_fe", 32'(out_data[0]), 32'd0);

        step(1, 20'h00100, 4'b0100, 8'h23, 1, 0);
        chk("beq_op", 32'(out_data[10:6]), 32'h0B);
        chk("beq_fe", 32'(out_data[0]), 32'd1);
        chk("beq_errcnt", 32'(err_cnt), 32'd3);
        step(0, 0, 0, 0, 1, 0);

        // Overfill with the sink stalled.
        for (int i = 0; i < DEPTH + 3; i++) step(1, 20'h80000, 4'b0100, 8'(8'h40 + i), 0, 0);
        chk("full_drop", 32'(drop_cnt), 32'd3);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_data", 32'(out_data[18:11]), 32'h40);
        step(1, 20'h00008, 4'b0101, 8'h50, 1, 0);
        chk("pushpop_drop", 32'(drop_cnt), 32'd3);
        chk("pushpop_head", 32'(out_data[18:11]), 32'h41);

        step(1, 20'h00004, 4'b0100, 8'h51, 0, 1);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_hold", 32'(out_valid), 32'd1);
        for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 1, 0);
        chk("drained", 32'(out_valid), 32'd0);

        // Fill 5 (one erroneous), then asynchronous reset mid-cycle.
        for (int i = 0; i < 5; i++) step(1, (i == 2) ? 20'h00003 : 20'h00001, 4'b0100, 8'(8'h60 + i), 0, 0);
        chk("fill_err", 32'(err_cnt), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_err", 32'(err_cnt), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        #1 rst_n = 1'b1;
        step(1, 20'h00002, 4'b0100, 8'h70, 0, 0);
        chk("post_rst_data", 32'(out_data), 32'({8'h70, 5'b11110, 4'b0100, 2'b00}));
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
